// File: rtl/bcd_scan_display.sv
// Two-digit multiplexed seven-segment driver for a bcd_adder result.
// Holds the captured sum/carry and scans units, gap, tens, gap onto one active-low bus.
module bcd_scan_display #(
    parameter int DIGIT_CYCLES = 8,
    parameter int GAP_CYCLES   = 2,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] s,
    input  logic       c,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int MAX_N = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
    localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef enum logic [1:0] {
        UNITS,
        GAP_U,
        TENS,
        GAP_T
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       s_q;
    logic             c_q;
    logic             err_q;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_E;
        endcase
        return g;
    endfunction

    // Held data loads independently of the scan; reset wins over load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= UNITS;
            cnt_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                s_q   <= s;
                c_q   <= c;
                err_q <= (s > 4'd9);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        an      = 2'b11;
        seg     = SEG_BLANK;
        case (state_q)
            UNITS: begin
                an  = 2'b10;
                seg = err_q ? SEG_E : glyph(s_q);
                if (cnt_q == DIG_LAST) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? GAP_U : TENS;
                end
            end
            GAP_U: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = TENS;
                end
            end
            TENS: begin
                an = 2'b01;
                if (err_q)
                    seg = SEG_E;
                else if (c_q)
                    seg = glyph(4'd1);
                else if (BLANK_LZ)
                    seg = SEG_BLANK;
                else
                    seg = glyph(4'd0);
                if (cnt_q == DIG_LAST) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? GAP_T : UNITS;
                end
            end
            GAP_T: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = UNITS;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = UNITS;
            end
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: four parameterisations share one stimulus stream and are
// checked every cycle against a scan-position model, plus hand-computed spot values.
module tb_bcd_scan_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] s = 4'd0;
    logic       c = 1'b0;

    logic [6:0] seg_w [4];
    logic [1:0] an_w  [4];
    logic       err_w [4];

    // Instance parameters: default, BLANK_LZ=0, GAP_CYCLES=0, minimal 1/1.
    int dc_tab  [4] = '{8, 8, 8, 1};
    int gc_tab  [4] = '{2, 2, 0, 1};
    int blz_tab [4] = '{1, 0, 1, 1};

    logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};

    int n_vec  = 0;
    int n_fail = 0;

    int         t_m = 0;
    logic [3:0] s_m = 4'd0;
    logic       c_m = 1'b0;
    bit         model_ok = 1'b0;

    bcd_scan_display #(.DIGIT_CYCLES(8), .GAP_CYCLES(2), .BLANK_LZ(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .load(load), .s(s), .c(c),
        .seg(seg_w[0]), .an(an_w[0]), .err(err_w[0]));
    bcd_scan_display #(.DIGIT_CYCLES(8), .GAP_CYCLES(2), .BLANK_LZ(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .s(s), .c(c),
        .seg(seg_w[1]), .an(an_w[1]), .err(err_w[1]));
    bcd_scan_display #(.DIGIT_CYCLES(8), .GAP_CYCLES(0), .BLANK_LZ(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .load(load), .s(s), .c(c),
        .seg(seg_w[2]), .an(an_w[2]), .err(err_w[2]));
    bcd_scan_display #(.DIGIT_CYCLES(1), .GAP_CYCLES(1), .BLANK_LZ(1'b1)) dut3 (
        .clk(clk), .rst_n(rst_n), .load(load), .s(s), .c(c),
        .seg(seg_w[3]), .an(an_w[3]), .err(err_w[3]));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b (t=%0d)", name, act, exp, t_m);
        end
    endtask

    // Expected outputs from the position within the scan period since the last reset.
    function automatic void model(input int dc, input int gc, input int blz, input int t,
                                  input logic [3:0] sh, input logic ch,
                                  output logic [1:0] an_e, output logic [6:0] seg_e);
        int  p;
        bit  e;
        p = t % (2 * dc + 2 * gc);
        e = (sh > 9);
        an_e  = 2'b11;
        seg_e = 7'b1111111;
        if (p < dc) begin
            an_e  = 2'b10;
            seg_e = e ? 7'b0000110 : glyph_tab[sh];
        end else if (p >= dc + gc && p < 2 * dc + gc) begin
            an_e = 2'b01;
            if (e)            seg_e = 7'b0000110;
            else if (ch)      seg_e = glyph_tab[1];
            else if (blz == 0) seg_e = glyph_tab[0];
        end
    endfunction

    initial begin
        logic [1:0] an_e;
        logic [6:0] seg_e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                t_m = 0; s_m = 4'd0; c_m = 1'b0; model_ok = 1'b1;
            end else if (model_ok) begin
                t_m++;
                if (load) begin s_m = s; c_m = c; end
            end
            @(negedge clk);
            if (model_ok) begin
                for (int i = 0; i < 4; i++) begin
                    model(dc_tab[i], gc_tab[i], blz_tab[i], t_m, s_m, c_m, an_e, seg_e);
                    chk($sformatf("an[%0d]", i), 32'(an_w[i]), 32'(an_e));
                    chk($sformatf("seg[%0d]", i), 32'(seg_w[i]), 32'(seg_e));
                    chk($sformatf("err[%0d]", i), 32'(err_w[i]), 32'(s_m > 9));
                    n_vec++;
                    if (an_w[i] == 2'b00) begin
                        n_fail++;
                        $display("FAIL an_both_low[%0d]: got %b want not 00", i, an_w[i]);
                    end
                    if (gc_tab[i] == 0) begin
                        n_vec++;
                        if (an_w[i] == 2'b11) begin
                            n_fail++;
                            $display("FAIL nogap_an[%0d]: got %b want not 11", i, an_w[i]);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int target);
        int budget;
        budget = 1000;
        while (t_m < target && budget > 0) begin
            tick();
            budget--;
        end
        chk("run_to", 32'(t_m), 32'(target));
    endtask

    task automatic do_load(input logic [3:0] sv, input logic cv);
        load = 1'b1; s = sv; c = cv;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_an", 32'(an_w[0]), 32'(2'b10));
        chk("rst_seg", 32'(seg_w[0]), 32'(7'b1000000));
        chk("rst_err", 32'(err_w[0]), 32'(1'b0));
        chk("rst_seg_lz0", 32'(seg_w[1]), 32'(7'b1000000));

        run_to(10);
        chk("idle_tens_an", 32'(an_w[0]), 32'(2'b01));
        chk("idle_tens_blank", 32'(seg_w[0]), 32'(7'b1111111));
        chk("idle_tens_lz0", 32'(seg_w[1]), 32'(7'b1000000));
        chk("nogap_tens_an", 32'(an_w[2]), 32'(2'b01));

        run_to(40);
        do_load(4'd9, 1'b0);
        chk("nine_units", 32'(seg_w[0]), 32'(7'b0010000));
        chk("nine_err", 32'(err_w[0]), 32'(1'b0));
        run_to(50);
        chk("nine_tens_blank", 32'(seg_w[0]), 32'(7'b1111111));
        chk("nine_tens_lz0", 32'(seg_w[1]), 32'(7'b1000000));

        do_load(4'd6, 1'b1);
        chk("sixteen_tens", 32'(seg_w[0]), 32'(7'b1111001));
        chk("sixteen_tens_an", 32'(an_w[0]), 32'(2'b01));
        run_to(60);
        chk("sixteen_units", 32'(seg_w[0]), 32'(7'b0000010));

        do_load(4'd12, 1'b0);
        chk("bad_err", 32'(err_w[0]), 32'(1'b1));
        chk("bad_units_e", 32'(seg_w[0]), 32'(7'b0000110));
        run_to(70);
        chk("bad_tens_e", 32'(seg_w[0]), 32'(7'b0000110));
        do_load(4'd3, 1'b0);
        chk("fix_err", 32'(err_w[0]), 32'(1'b0));
        run_to(80);
        chk("three_units", 32'(seg_w[0]), 32'(7'b0110000));

        run_to(83);
        do_load(4'd5, 1'b0);
        chk("midload_seg", 32'(seg_w[0]), 32'(7'b0010010));
        chk("midload_an", 32'(an_w[0]), 32'(2'b10));
        run_to(87);
        chk("dwell_end_an", 32'(an_w[0]), 32'(2'b10));
        run_to(88);
        chk("gap_after_an", 32'(an_w[0]), 32'(2'b11));
        run_to(100);
        chk("period_an", 32'(an_w[0]), 32'(2'b10));

        run_to(112);
        rst_n = 1'b0; load = 1'b1; s = 4'd7; c = 1'b1;
        tick();
        rst_n = 1'b1; load = 1'b0;
        chk("midrst_an", 32'(an_w[0]), 32'(2'b10));
        chk("midrst_seg", 32'(seg_w[0]), 32'(7'b1000000));
        chk("midrst_err", 32'(err_w[0]), 32'(1'b0));

        for (int i = 0; i < 12; i++) begin
            load = 1'b1; s = 4'(i + 3); c = 1'(i);
            tick();
        end
        load = 1'b0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
